trng_health_gate: RTL

//  Downstream stage of the 8-bit LFSR PRNG core. Runs two online health tests on every

---
 rtl/trng_pkg.sv | 19 +
 rtl/trng_sync_fifo.sv | 62 ++++++
 rtl/trng_health_gate.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared state encoding and default cutoffs for the
// TRNG health gate.
package trng_pkg;

  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;

  localparam int RCT_CUTOFF_DEF = 4;
  localparam int APT_WINDOW_DEF = 64;
  localparam int APT_CUTOFF_DEF = 6;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic rct;
    logic apt;
  } trip_t;

endpackage

// File: rtl/trng_sync_fifo.sv
// Small synchronous FIFO with flush; a push into a
// full FIFO succeeds when a pop happens in the same cycle.
module trng_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trng_health_gate.sv
// Online RCT/APT health tests on PRNG bytes, gating a
// small output FIFO behind a STARTUP/RUN/FAIL controller.
module trng_health_gate
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       clear_alarm,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       alarm_rct,
  output logic       alarm_apt,
  output logic       overflow,
  output logic       healthy
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_CUTOFF + 1);
  localparam int WW = $clog2(APT_WINDOW + 1);

  localparam logic [RW-1:0] RCT_LIM = RW'(RCT_CUTOFF);
  localparam logic [AW-1:0] APT_LIM = AW'(APT_CUTOFF);
  localparam logic [WW-1:0] WIN_LIM = WW'(APT_WINDOW);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [7:0]    last_q;
  logic [7:0]    ref_q;
  logic [7:0]    ref_d;
  logic [RW-1:0] rct_q;
  logic [RW-1:0] rct_d;
  logic [AW-1:0] apt_q;
  logic [AW-1:0] apt_d;
  logic [WW-1:0] win_q;
  logic [WW-1:0] win_d;
  logic          rct_alarm_q;
  logic          apt_alarm_q;
  logic          ovf_q;

  logic  testing;
  logic  active;
  logic  new_win;
  logic  alarm;
  logic  run_pass;
  logic  clear;
  trip_t trip;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;

  assign testing = (state_q == ST_STARTUP) ||
                   (state_q == ST_RUN);
  assign active  = sample_valid && testing;
  assign new_win = (win_q == '0) || (win_q == WIN_LIM);

  // rct_q == 0 marks "no previous sample since reset/clear"
  always_comb begin
    rct_d = RW'(1);
    if (rct_q != '0 && sample_in == last_q) begin
      rct_d = (&rct_q) ? rct_q : rct_q + 1'b1;
    end
    ref_d = ref_q;
    apt_d = apt_q;
    win_d = win_q;
    if (new_win) begin
      ref_d = sample_in;
      apt_d = AW'(1);
      win_d = WW'(1);
    end else begin
      win_d = win_q + 1'b1;
      if (sample_in == ref_q && !(&apt_q)) begin
        apt_d = apt_q + 1'b1;
      end
    end
  end

  assign trip.rct = active && (rct_d >= RCT_LIM);
  assign trip.apt = active && (apt_d >= APT_LIM);
  assign alarm    = trip.rct || trip.apt;
  assign run_pass = active && !alarm &&
                    (state_q == ST_RUN);
  assign clear    = (state_q == ST_FAIL) && clear_alarm;

  assign out_valid = (state_q == ST_RUN) && !fifo_empty;
  assign out_data  = out_valid ? fifo_rdata : 8'h00;
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = run_pass && (!fifo_full || fifo_pop);
  assign healthy   = (state_q == ST_RUN);
  assign alarm_rct = rct_alarm_q;
  assign alarm_apt = apt_alarm_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == ST_STARTUP: begin
        if (alarm) begin
          state_d = ST_FAIL;
        end else if (active && win_d == WIN_LIM) begin
          state_d = ST_RUN;
        end
      end
      state_q == ST_RUN: begin
        if (alarm) begin
          state_d = ST_FAIL;
        end
      end
      state_q == ST_FAIL: begin
        if (clear_alarm) begin
          state_d = ST_STARTUP;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STARTUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_q  <= '0;
      apt_q  <= '0;
      win_q  <= '0;
      ref_q  <= '0;
      last_q <= '0;
    end else if (clear) begin
      rct_q  <= '0;
      apt_q  <= '0;
      win_q  <= '0;
      ref_q  <= '0;
      last_q <= '0;
    end else if (active) begin
      rct_q  <= rct_d;
      apt_q  <= apt_d;
      win_q  <= win_d;
      ref_q  <= ref_d;
      last_q <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_alarm_q <= 1'b0;
      apt_alarm_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clear) begin
      rct_alarm_q <= 1'b0;
      apt_alarm_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (trip.rct) begin
        rct_alarm_q <= 1'b1;
      end
      if (trip.apt) begin
        apt_alarm_q <= 1'b1;
      end
      // dropped byte: full FIFO with no pop to make room
      if (run_pass && fifo_full && !fifo_pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  trng_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (alarm),
    .wdata (sample_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
